decode_stage: RTL and testbench

- Instruction-decode (ID) stage of the pipelined 64-bit LEGv8/ARMv8 core.
- Splits the 32-bit instruction into opcode, register specifiers and a sign-extended immediate.
- Contains the 32×64 register file: two combinational read ports and one synchronous write port driven by write-back.
- Sits between the IF/ID and ID/EX pipeline registers; it holds no pipeline register itself.

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/reg_file.sv | 59 +++++
 rtl/decode_stage.sv | 84 ++++++++
 tb/tb_decode_stage.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared opcode constants, instruction-format encoding and
//                register index constants for the LEGv8 decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Full 11-bit opcodes (instruction[31:21])
    localparam logic [10:0] LDUR  = 11'b11111000010;
    localparam logic [10:0] STUR  = 11'b11111000000;

    // CB-type opcodes are 8 bits wide (instruction[31:24])
    localparam logic [7:0]  CBZ   = 8'b10110100;
    localparam logic [7:0]  CBNZ  = 8'b10110101;

    // B-type opcodes are 6 bits wide (instruction[31:26])
    localparam logic [5:0]  B     = 6'b000101;
    localparam logic [5:0]  BL    = 6'b100101;

    // I-type opcodes are 10 bits wide (instruction[31:22])
    localparam logic [9:0]  ADDI  = 10'b1001000100;
    localparam logic [9:0]  SUBI  = 10'b1101000100;
    localparam logic [9:0]  ADDIS = 10'b1011000100;
    localparam logic [9:0]  SUBIS = 10'b1111000100;

    // Zero register index
    localparam logic [4:0]  XZR   = 5'd31;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_B  = 3'd3,
        FMT_CB = 3'd4
    } fmt_e;

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : 32 x 64 register file, two combinational read ports, one
//                synchronous write port, async active-high clear. Index 31
//                (XZR) always reads zero and ignores writes.
//                Optional macro DECODE_WB_BYPASS_EN forwards the write-back
//                data to a read port addressing the register being written.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_reg_write,
    input  logic [4:0]      i_write_reg,
    input  logic [XLEN-1:0] i_write_data,
    input  logic [4:0]      i_read_addr_one,
    input  logic [4:0]      i_read_addr_two,
    output logic [XLEN-1:0] o_read_data_one,
    output logic [XLEN-1:0] o_read_data_two
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_en;

    assign w_wr_en = i_reg_write && (i_write_reg != XZR);

    // Storage: async clear, write-back on the rising edge (XZR writes dropped)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_write_reg] <= i_write_data;
        end
    end

    // Read ports: XZR reads zero; optional same-cycle write-through
    always_comb begin
        o_read_data_one = (i_read_addr_one == XZR) ? '0 : r_regs[i_read_addr_one];
        o_read_data_two = (i_read_addr_two == XZR) ? '0 : r_regs[i_read_addr_two];
`ifdef DECODE_WB_BYPASS_EN
        if (w_wr_en && (i_write_reg == i_read_addr_one)) begin
            o_read_data_one = i_write_data;
        end
        if (w_wr_en && (i_write_reg == i_read_addr_two)) begin
            o_read_data_two = i_write_data;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : LEGv8 instruction-decode stage. Splits the instruction into
//                fields, selects the second read register (Reg2Loc), builds
//                the format-dependent immediate and hosts the register file.
//                Optional macro DECODE_WB_BYPASS_EN enables WB->ID forwarding
//                inside the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic            reg_write,
    input  logic [4:0]      write_reg,
    input  logic [XLEN-1:0] write_data,
    output logic [10:0]     op_code,
    output logic [XLEN-1:0] read_data_num_one,
    output logic [XLEN-1:0] read_data_num_two,
    output logic [XLEN-1:0] sign_extended_imm,
    output logic [4:0]      dest_reg
);

    fmt_e       w_fmt;
    logic       w_reg2loc;
    logic [4:0] w_read_addr_two;

    assign op_code  = instruction[31:21];
    assign dest_reg = instruction[4:0];

    // STUR and CBZ read Rt (instruction[4:0]) as their second operand
    assign w_reg2loc       = (op_code == STUR) || (op_code[10:3] == CBZ);
    assign w_read_addr_two = w_reg2loc ? instruction[4:0] : instruction[20:16];

    // Opcode classifier: anything unrecognised is treated as R-type
    always_comb begin
        w_fmt = FMT_R;
        if ((op_code[10:1] == LDUR[10:1]) || (op_code[10:1] == STUR[10:1])) begin
            w_fmt = FMT_D;
        end else if ((op_code[10:3] == CBZ) || (op_code[10:3] == CBNZ)) begin
            w_fmt = FMT_CB;
        end else if ((op_code[10:5] == B) || (op_code[10:5] == BL)) begin
            w_fmt = FMT_B;
        end else if ((op_code[10:1] == ADDI)  || (op_code[10:1] == SUBI) ||
                     (op_code[10:1] == ADDIS) || (op_code[10:1] == SUBIS)) begin
            w_fmt = FMT_I;
        end
    end

    // Immediate generator: sign-extend D/CB/B offsets, zero-extend I-type
    always_comb begin
        sign_extended_imm = '0;
        case (w_fmt)
            FMT_D:   sign_extended_imm = {{(XLEN-9){instruction[20]}},  instruction[20:12]};
            FMT_CB:  sign_extended_imm = {{(XLEN-19){instruction[23]}}, instruction[23:5]};
            FMT_B:   sign_extended_imm = {{(XLEN-26){instruction[25]}}, instruction[25:0]};
            FMT_I:   sign_extended_imm = {{(XLEN-12){1'b0}},            instruction[21:10]};
            default: sign_extended_imm = '0;
        endcase
    end

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk             (clk),
        .rst             (reset),
        .i_reg_write     (reg_write),
        .i_write_reg     (write_reg),
        .i_write_data    (write_data),
        .i_read_addr_one (instruction[9:5]),
        .i_read_addr_two (w_read_addr_two),
        .o_read_data_one (read_data_num_one),
        .o_read_data_two (read_data_num_two)
    );

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage. Directed vectors push
//                hand-computed expectations into a queue; a monitor pops and
//                compares them against the DUT outputs mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic [10:0] op_code;
    logic [63:0] read_data_num_one;
    logic [63:0] read_data_num_two;
    logic [63:0] sign_extended_imm;
    logic [4:0]  dest_reg;

    typedef struct {
        logic [8*12-1:0] name;
        logic [63:0]     rd1;
        logic [63:0]     rd2;
        logic [63:0]     imm;
        logic [10:0]     op;
        logic [4:0]      dst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef DECODE_WB_BYPASS_EN
    localparam logic [63:0] BYP55 = 64'h55;
`else
    localparam logic [63:0] BYP55 = 64'h0;
`endif

    decode_stage dut (
        .clk               (clk),
        .reset             (reset),
        .instruction       (instruction),
        .reg_write         (reg_write),
        .write_reg         (write_reg),
        .write_data        (write_data),
        .op_code           (op_code),
        .read_data_num_one (read_data_num_one),
        .read_data_num_two (read_data_num_two),
        .sign_extended_imm (sign_extended_imm),
        .dest_reg          (dest_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [8*12-1:0] name, input string field,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %0s.%0s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Drive a vector on the falling edge and queue its expected outputs
    task automatic drive(input logic [8*12-1:0] name, input logic rst_v,
                         input logic [31:0] ins, input logic we,
                         input logic [4:0] wr, input logic [63:0] wd,
                         input logic [63:0] e_rd1, input logic [63:0] e_rd2,
                         input logic [63:0] e_imm, input logic [10:0] e_op,
                         input logic [4:0] e_dst);
        exp_t e;
        @(negedge clk);
        reset       = rst_v;
        instruction = ins;
        reg_write   = we;
        write_reg   = wr;
        write_data  = wd;
        e.name = name; e.rd1 = e_rd1; e.rd2 = e_rd2;
        e.imm  = e_imm; e.op = e_op; e.dst = e_dst;
        exp_q.push_back(e);
    endtask

    // Monitor: compare queued expectations 3 time units after each falling edge
    initial begin
        forever begin
            @(negedge clk);
            #3;
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.name, "rd1", read_data_num_one, e.rd1);
                chk(e.name, "rd2", read_data_num_two, e.rd2);
                chk(e.name, "imm", sign_extended_imm, e.imm);
                chk(e.name, "op",  {53'd0, op_code},  {53'd0, e.op});
                chk(e.name, "dst", {59'd0, dest_reg}, {59'd0, e.dst});
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; instruction = '0; reg_write = 1'b0; write_reg = '0; write_data = '0;
        //     name          rst  instr         we  wr     wd          rd1        rd2        imm                     op       dst
        drive("in_reset",    1, 32'h00000000, 0, 5'd0,  64'd0,      64'd0,     64'd0,     64'd0,                  11'h000, 5'd0);
        drive("zero_instr",  0, 32'h00000000, 0, 5'd0,  64'd0,      64'd0,     64'd0,     64'd0,                  11'h000, 5'd0);
        drive("wr_x1",       0, 32'h00000001, 1, 5'd1,  64'd32,     64'd0,     64'd0,     64'd0,                  11'h000, 5'd1);
        drive("wr_x2",       0, 32'h00000020, 1, 5'd2,  64'd64,     64'd32,    64'd0,     64'd0,                  11'h000, 5'd0);
        drive("rd_rm2",      0, 32'h00220000, 0, 5'd0,  64'd0,      64'd0,     64'd64,    64'd0,                  11'h001, 5'd0);
        drive("wr_xzr",      0, 32'h001F03E0, 1, 5'd31, 64'd64,     64'd0,     64'd0,     64'd0,                  11'h000, 5'd0);
        drive("rd_xzr",      0, 32'h001F03E0, 0, 5'd0,  64'd0,      64'd0,     64'd0,     64'd0,                  11'h000, 5'd0);
        drive("ldur",        0, 32'hF85F8041, 1, 5'd3,  64'h1234,   64'd64,    64'd0,     64'hFFFFFFFFFFFFFFF8,   11'h7C2, 5'd1);
        drive("cbz",         0, 32'hB4FFFFE3, 0, 5'd0,  64'd0,      64'd0,     64'h1234,  64'hFFFFFFFFFFFFFFFF,   11'h5A7, 5'd3);
        drive("cbnz",        0, 32'hB5000043, 0, 5'd0,  64'd0,      64'd64,    64'd0,     64'd2,                  11'h5A8, 5'd3);
        drive("stur",        0, 32'hF81FF041, 0, 5'd0,  64'd0,      64'd64,    64'd32,    64'hFFFFFFFFFFFFFFFF,   11'h7C0, 5'd1);
        drive("b_pos",       0, 32'h14000010, 0, 5'd0,  64'd0,      64'd0,     64'd0,     64'd16,                 11'h0A0, 5'd16);
        drive("bl_neg",      0, 32'h97FFFFFE, 0, 5'd0,  64'd0,      64'd0,     64'd0,     64'hFFFFFFFFFFFFFFFE,   11'h4BF, 5'd30);
        drive("addi",        0, 32'h913FFC24, 0, 5'd0,  64'd0,      64'd32,    64'd0,     64'd4095,               11'h489, 5'd4);
        // Reset with a concurrent write: write to x6 must be lost, x1 cleared
        drive("rst_wr",      1, 32'h00000020, 1, 5'd6,  64'h66,     64'd0,     64'd0,     64'd0,                  11'h000, 5'd0);
        drive("rd_x6",       0, 32'h000600C0, 0, 5'd0,  64'd0,      64'd0,     64'd0,     64'd0,                  11'h000, 5'd0);
        drive("x5_clear",    0, 32'h000500A0, 0, 5'd0,  64'd0,      64'd0,     64'd0,     64'd0,                  11'h000, 5'd0);
        drive("x5_same",     0, 32'h000500A0, 1, 5'd5,  64'h55,     BYP55,     BYP55,     64'd0,                  11'h000, 5'd0);
        drive("x5_after",    0, 32'h000500A0, 0, 5'd0,  64'd0,      64'h55,    64'h55,    64'd0,                  11'h000, 5'd0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
